fb_write_arbiter: RTL and testbench
===================================

// Module: fb_write_arbiter
// PURPOSE
//  Shares the single framebuffer write port between N pixel-stream requesters:
//  clear engine, square drawer and player drawer.
//  Grants the port to one requester for a whole burst, which ends on req_last.
//  Range-checks each pixel and drops off-screen pixels.
//  Computes the linear address and drives the registered write to the memory block.
// PARAMETERS
//  N_REQ      3    number of requesters (index 0 = highest priority)
//  PX_WIDTH   160  screen width in pixels
//  PX_HEIGHT  120  screen height in pixels
//  COORD_W    9    signed coordinate width
//  COLOR_W    3    pixel colour width
//  ADDR_W     16   framebuffer address width
//  RR         0    0 = fixed priority; 1 = round-robin starting after last owner
// PORTS
//  clk         in   1                clock, rising edge
//  rst_n       in   1                async active-low reset
//  req_valid   in   N_REQ            requester i has a pixel
//  req_ready   out  N_REQ            pixel of requester i consumed this cycle
//  req_x       in   N_REQ*COORD_W    signed x, slice i
//  req_y       in   N_REQ*COORD_W    signed y, slice i
//  req_color   in   N_REQ*COLOR_W    colour, slice i
//  req_last    in   N_REQ            final pixel of burst, slice i
//  abort       in   1                force release of the current burst
//  mem_we      out  1                framebuffer write enable
//  mem_addr    out  ADDR_W           y*PX_WIDTH+x
//  mem_data    out  COLOR_W          pixel colour
//  busy        out  1                a burst is locked
//  owner       out  clog2(N_REQ)     current or last owner index
//  drop_cnt    out  16               saturating count of off-screen pixels
// BEHAVIOUR
//  Reset values (async, rst_n low): state=IDLE, req_ready=0, mem_we=0,
//  mem_addr=0, mem_data=0, busy=0, owner=0, drop_cnt=0.
//  States:
//   IDLE:
//    - req_ready all 0.
//    - If any req_valid, pick the winner (RR=0: lowest index; RR=1: first valid
//      index after owner, wrapping).
//    - owner<=winner, go to LOCKED. This is one arbitration bubble per burst.
//   LOCKED:
//    - req_ready[owner] = req_valid[owner] (combinational); all other readies are 0.
//    - Transfer = valid&ready.
//    - On a transfer with req_last: go to IDLE next cycle.
//  Owner deasserting valid mid-burst: remain LOCKED; no writes; gaps allowed.
//  Write latency: a pixel transferred in cycle t drives mem_we/addr/data in cycle t+1.
//   - On-screen (0<=x<PX_WIDTH, 0<=y<PX_HEIGHT, signed compare):
//     mem_we=1, mem_addr=y*PX_WIDTH+x truncated to ADDR_W.
//   - Off-screen: pixel is still consumed; mem_we=0; drop_cnt+1, saturating at 16'hFFFF.
//   - No transfer in cycle t: mem_we=0 in t+1; mem_addr/mem_data hold.
//  req_last on an off-screen pixel still ends the burst.
//  abort:
//   - In any state: next state IDLE, mem_we=0 next cycle.
//   - A transfer coincident with abort is discarded (ready still seen high).
//   - owner holds its value.
//  Requester asserting valid while another owns the port: waits, no loss.
//  Re-arbitration after a burst sees current valids; the same requester may win again.
//  busy = (state==LOCKED).
// STRUCTURE
//  consts.v (shared): PX_WIDTH, PX_HEIGHT, COORD_W, COLOR_W, requester IDs
//  REQ_CLR=0, REQ_SQ=1, REQ_PL=2, and the arbiter state encodings.
//  Sub-module fb_addr_calc: combinational range check plus y*PX_WIDTH+x,
//  outputs on_screen and addr.
//  Top level: FSM, winner select, output register stage.
// TESTING
//  1. Req0 burst of 3 at (0,0),(1,0),(2,0) colour 5, last on 3rd
//     -> mem_we 3 cycles at addr 0,1,2 data 5, each one cycle after ready;
//     busy drops.
//  2. Req1 and req2 valid together, RR=0 -> req1 burst completes first,
//     then one bubble, then req2. RR=1 with owner=1 -> req2 wins first.
//  3. Pixels (-1,5),(160,0),(3,120),(159,119) -> first three consumed,
//     mem_we=0, drop_cnt=3; last writes addr 19199.
//  4. abort asserted on 2nd pixel of a 4-pixel burst -> that pixel is not
//     written, IDLE next cycle, mem_we=0.
//  5. Owner drops valid 2 cycles mid-burst, req0 valid meanwhile -> stays
//     LOCKED, no req0 ready until owner's last.
//  6. rst_n pulsed low mid-burst (async, between edges) -> all outputs are
//     reset values immediately; a fresh arbitration follows release.

Source files
------------

// File: rtl/fb_write_arbiter_pkg.sv
// Shared constants, requester IDs and arbiter state encoding for the framebuffer write arbiter.
package fb_write_arbiter_pkg;

  localparam int DEF_N_REQ     = 3;
  localparam int DEF_PX_WIDTH  = 160;
  localparam int DEF_PX_HEIGHT = 120;
  localparam int DEF_COORD_W   = 9;
  localparam int DEF_COLOR_W   = 3;
  localparam int DEF_ADDR_W    = 16;

  localparam int REQ_CLR = 0;
  localparam int REQ_SQ  = 1;
  localparam int REQ_PL  = 2;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fb_write_arbiter_addr_calc.sv
// Signed on-screen range check and linear framebuffer address for one pixel.
module fb_write_arbiter_addr_calc
  import fb_write_arbiter_pkg::*;
#(
  parameter int PX_WIDTH  = DEF_PX_WIDTH,
  parameter int PX_HEIGHT = DEF_PX_HEIGHT,
  parameter int COORD_W   = DEF_COORD_W,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic signed [COORD_W-1:0] x,
  input  logic signed [COORD_W-1:0] y,
  output logic                      on_screen,
  output logic        [ADDR_W-1:0]  addr
);

  logic [31:0] lin_s;

  // Compare in 32-bit signed so a bound like 160 is not misread as negative at COORD_W bits
  assign on_screen = (int'(x) >= 32'sd0) && (int'(x) < PX_WIDTH) &&
                     (int'(y) >= 32'sd0) && (int'(y) < PX_HEIGHT);

  assign lin_s = 32'(y) * 32'(PX_WIDTH) + 32'(x);
  assign addr  = lin_s[ADDR_W-1:0];

endmodule

// File: rtl/fb_write_arbiter.sv
// Burst-locking arbiter sharing the framebuffer write port; drops off-screen pixels
// and registers the resulting write one cycle after each transfer.
module fb_write_arbiter
  import fb_write_arbiter_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int PX_WIDTH  = DEF_PX_WIDTH,
  parameter int PX_HEIGHT = DEF_PX_HEIGHT,
  parameter int COORD_W   = DEF_COORD_W,
  parameter int COLOR_W   = DEF_COLOR_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RR        = 0,
  localparam int OWN_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*COORD_W-1:0]   req_x,
  input  logic [N_REQ*COORD_W-1:0]   req_y,
  input  logic [N_REQ*COLOR_W-1:0]   req_color,
  input  logic [N_REQ-1:0]           req_last,
  input  logic                       abort,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [COLOR_W-1:0]         mem_data,
  output logic                       busy,
  output logic [OWN_W-1:0]           owner,
  output logic [15:0]                drop_cnt
);

  arb_state_e                state_r;
  logic [OWN_W-1:0]          owner_r;
  logic [OWN_W-1:0]          winner_s;
  logic [OWN_W-1:0]          rr_idx_s;
  logic [N_REQ-1:0]          ready_s;
  logic                      xfer_s;
  logic signed [COORD_W-1:0] sel_x_s;
  logic signed [COORD_W-1:0] sel_y_s;
  logic [COLOR_W-1:0]        sel_color_s;
  logic                      sel_last_s;
  logic                      on_screen_s;
  logic [ADDR_W-1:0]         addr_s;
  logic                      mem_we_r;
  logic [ADDR_W-1:0]         mem_addr_r;
  logic [COLOR_W-1:0]        mem_data_r;
  logic [15:0]               drop_cnt_r;

  // Winner select: scan from lowest to highest priority so the last hit wins
  always_comb begin
    winner_s = owner_r;
    rr_idx_s = '0;
    if (RR == 0) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        winner_s = req_valid[i] ? OWN_W'(i) : winner_s;
      end
    end else begin
      for (int k = N_REQ; k >= 1; k--) begin
        rr_idx_s = OWN_W'((int'(owner_r) + k) % N_REQ);
        winner_s = req_valid[rr_idx_s] ? rr_idx_s : winner_s;
      end
    end
  end

  // Only the locked owner sees ready, and only while it presents a pixel
  always_comb begin
    ready_s = '0;
    if (state_r == ST_LOCKED) begin
      ready_s[owner_r] = req_valid[owner_r];
    end else begin
      ready_s = '0;
    end
  end

  assign xfer_s      = |(ready_s & req_valid);
  assign sel_x_s     = req_x[int'(owner_r)*COORD_W +: COORD_W];
  assign sel_y_s     = req_y[int'(owner_r)*COORD_W +: COORD_W];
  assign sel_color_s = req_color[int'(owner_r)*COLOR_W +: COLOR_W];
  assign sel_last_s  = req_last[owner_r];

  fb_write_arbiter_addr_calc #(
    .PX_WIDTH (PX_WIDTH),
    .PX_HEIGHT(PX_HEIGHT),
    .COORD_W  (COORD_W),
    .ADDR_W   (ADDR_W)
  ) u_addr_calc (
    .x        (sel_x_s),
    .y        (sel_y_s),
    .on_screen(on_screen_s),
    .addr     (addr_s)
  );

  // Arbiter FSM and registered write stage; abort discards any coincident transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      owner_r    <= '0;
      mem_we_r   <= 1'b0;
      mem_addr_r <= '0;
      mem_data_r <= '0;
      drop_cnt_r <= 16'd0;
    end else begin
      mem_we_r <= 1'b0;
      if (abort) begin
        state_r <= ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (|req_valid) begin
              owner_r <= winner_s;
              state_r <= ST_LOCKED;
            end
          end
          ST_LOCKED: begin
            if (xfer_s) begin
              if (on_screen_s) begin
                mem_we_r   <= 1'b1;
                mem_addr_r <= addr_s;
                mem_data_r <= sel_color_s;
              end else begin
                drop_cnt_r <= sat_inc16(drop_cnt_r);
              end
              if (sel_last_s) begin
                state_r <= ST_IDLE;
              end
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

  assign req_ready = ready_s;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_data  = mem_data_r;
  assign busy      = (state_r == ST_LOCKED);
  assign owner     = owner_r;
  assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed table-driven bench for fb_write_arbiter plus round-robin and async-reset sequences.
module tb_fb_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [26:0] req_x;
  logic [26:0] req_y;
  logic [8:0]  req_color;
  logic [2:0]  req_last;
  logic        abort;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [2:0]  mem_data;
  logic        busy;
  logic [1:0]  owner;
  logic [15:0] drop_cnt;

  logic [2:0]  rr_valid;
  logic [2:0]  rr_ready;
  logic [2:0]  rr_last;
  logic        rr_abort;
  logic        rr_we;
  logic [15:0] rr_addr;
  logic [2:0]  rr_data;
  logic        rr_busy;
  logic [1:0]  rr_owner;
  logic [15:0] rr_drop;

  int checks;
  int errors;

  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  last;
    int          x;
    int          y;
    logic [2:0]  color;
    logic        abrt;
    logic [2:0]  ready;
    logic        we;
    logic [15:0] addr;
    logic [2:0]  data;
    logic        bsy;
    logic [1:0]  own;
    logic [15:0] drops;
  } vec_t;

  vec_t vecs[$];

  fb_write_arbiter #(.RR(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_color(req_color), .req_last(req_last),
    .abort(abort), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .owner(owner), .drop_cnt(drop_cnt)
  );

  fb_write_arbiter #(.RR(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req_valid(rr_valid), .req_ready(rr_ready),
    .req_x(req_x), .req_y(req_y), .req_color(req_color), .req_last(rr_last),
    .abort(rr_abort), .mem_we(rr_we), .mem_addr(rr_addr), .mem_data(rr_data),
    .busy(rr_busy), .owner(rr_owner), .drop_cnt(rr_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] valid, input logic [2:0] last, input int x, input int y,
                     input logic [2:0] color, input logic abrt, input logic [2:0] ready,
                     input logic we, input logic [15:0] addr, input logic [2:0] data,
                     input logic bsy, input logic [1:0] own, input logic [15:0] drops);
    vec_t v;
    v.valid = valid; v.last = last; v.x = x; v.y = y; v.color = color; v.abrt = abrt;
    v.ready = ready; v.we = we; v.addr = addr; v.data = data; v.bsy = bsy; v.own = own;
    v.drops = drops;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [2:0] valid, input logic [2:0] last, input int x, input int y,
                       input logic [2:0] color, input logic abrt);
    logic [8:0] xs;
    logic [8:0] ys;
    xs = 9'(x);
    ys = 9'(y);
    req_valid = valid;
    req_last  = last;
    req_x     = {3{xs}};
    req_y     = {3{ys}};
    req_color = {3{color}};
    abort     = abrt;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    rr_valid = 3'b000; rr_last = 3'b000; rr_abort = 1'b0;
    drive(3'b000, 3'b000, 0, 0, 3'd0, 1'b0);

    // burst of three on-screen pixels from requester 0
    add(3'b001, 3'b000,   0,   0, 3'd5, 1'b0, 3'b000, 1'b0, 16'd0,     3'd0, 1'b0, 2'd0, 16'd0);
    add(3'b001, 3'b000,   0,   0, 3'd5, 1'b0, 3'b001, 1'b0, 16'd0,     3'd0, 1'b1, 2'd0, 16'd0);
    add(3'b001, 3'b000,   1,   0, 3'd5, 1'b0, 3'b001, 1'b1, 16'd0,     3'd5, 1'b1, 2'd0, 16'd0);
    add(3'b001, 3'b001,   2,   0, 3'd5, 1'b0, 3'b001, 1'b1, 16'd1,     3'd5, 1'b1, 2'd0, 16'd0);
    add(3'b000, 3'b000,   0,   0, 3'd0, 1'b0, 3'b000, 1'b1, 16'd2,     3'd5, 1'b0, 2'd0, 16'd0);
    add(3'b000, 3'b000,   0,   0, 3'd0, 1'b0, 3'b000, 1'b0, 16'd0,     3'd0, 1'b0, 2'd0, 16'd0);
    // requesters 1 and 2 together, fixed priority
    add(3'b110, 3'b000,  10,   1, 3'd3, 1'b0, 3'b000, 1'b0, 16'd0,     3'd0, 1'b0, 2'd0, 16'd0);
    add(3'b110, 3'b000,  10,   1, 3'd3, 1'b0, 3'b010, 1'b0, 16'd0,     3'd0, 1'b1, 2'd1, 16'd0);
    add(3'b110, 3'b010,  11,   1, 3'd3, 1'b0, 3'b010, 1'b1, 16'd170,   3'd3, 1'b1, 2'd1, 16'd0);
    add(3'b100, 3'b000,  12,   1, 3'd3, 1'b0, 3'b000, 1'b1, 16'd171,   3'd3, 1'b0, 2'd1, 16'd0);
    add(3'b100, 3'b100,  12,   1, 3'd3, 1'b0, 3'b100, 1'b0, 16'd0,     3'd0, 1'b1, 2'd2, 16'd0);
    add(3'b000, 3'b000,   0,   0, 3'd0, 1'b0, 3'b000, 1'b1, 16'd172,   3'd3, 1'b0, 2'd2, 16'd0);
    // off-screen pixels are consumed and counted; the corner pixel is written
    add(3'b001, 3'b000,  -1,   5, 3'd6, 1'b0, 3'b000, 1'b0, 16'd0,     3'd0, 1'b0, 2'd2, 16'd0);
    add(3'b001, 3'b000,  -1,   5, 3'd6, 1'b0, 3'b001, 1'b0, 16'd0,     3'd0, 1'b1, 2'd0, 16'd0);
    add(3'b001, 3'b000, 160,   0, 3'd6, 1'b0, 3'b001, 1'b0, 16'd0,     3'd0, 1'b1, 2'd0, 16'd1);
    add(3'b001, 3'b000,   3, 120, 3'd6, 1'b0, 3'b001, 1'b0, 16'd0,     3'd0, 1'b1, 2'd0, 16'd2);
    add(3'b001, 3'b001, 159, 119, 3'd6, 1'b0, 3'b001, 1'b0, 16'd0,     3'd0, 1'b1, 2'd0, 16'd3);
    add(3'b000, 3'b000,   0,   0, 3'd0, 1'b0, 3'b000, 1'b1, 16'd19199, 3'd6, 1'b0, 2'd0, 16'd3);
    // abort on the second pixel of a burst
    add(3'b010, 3'b000,  20,   2, 3'd1, 1'b0, 3'b000, 1'b0, 16'd0,     3'd0, 1'b0, 2'd0, 16'd3);
    add(3'b010, 3'b000,  20,   2, 3'd1, 1'b0, 3'b010, 1'b0, 16'd0,     3'd0, 1'b1, 2'd1, 16'd3);
    add(3'b010, 3'b000,  21,   2, 3'd1, 1'b1, 3'b010, 1'b1, 16'd340,   3'd1, 1'b1, 2'd1, 16'd3);
    add(3'b000, 3'b000,   0,   0, 3'd0, 1'b0, 3'b000, 1'b0, 16'd0,     3'd0, 1'b0, 2'd1, 16'd3);
    // owner gap with requester 0 waiting
    add(3'b100, 3'b000,   0,   1, 3'd7, 1'b0, 3'b000, 1'b0, 16'd0,     3'd0, 1'b0, 2'd1, 16'd3);
    add(3'b100, 3'b000,   0,   1, 3'd7, 1'b0, 3'b100, 1'b0, 16'd0,     3'd0, 1'b1, 2'd2, 16'd3);
    add(3'b001, 3'b000,   1,   1, 3'd7, 1'b0, 3'b000, 1'b1, 16'd160,   3'd7, 1'b1, 2'd2, 16'd3);
    add(3'b001, 3'b000,   1,   1, 3'd7, 1'b0, 3'b000, 1'b0, 16'd0,     3'd0, 1'b1, 2'd2, 16'd3);
    add(3'b101, 3'b100,   1,   1, 3'd7, 1'b0, 3'b100, 1'b0, 16'd0,     3'd0, 1'b1, 2'd2, 16'd3);
    add(3'b001, 3'b001,   1,   1, 3'd7, 1'b0, 3'b000, 1'b1, 16'd161,   3'd7, 1'b0, 2'd2, 16'd3);
    add(3'b001, 3'b001,   1,   1, 3'd7, 1'b0, 3'b001, 1'b0, 16'd0,     3'd0, 1'b1, 2'd0, 16'd3);
    add(3'b000, 3'b000,   0,   0, 3'd0, 1'b0, 3'b000, 1'b1, 16'd161,   3'd7, 1'b0, 2'd0, 16'd3);

    repeat (2) @(negedge clk);
    chk("reset_we", 32'(mem_we), 32'd0);
    chk("reset_addr", 32'(mem_addr), 32'd0);
    chk("reset_data", 32'(mem_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_owner", 32'(owner), 32'd0);
    chk("reset_drop", 32'(drop_cnt), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].last, vecs[i].x, vecs[i].y, vecs[i].color, vecs[i].abrt);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].ready));
      chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(vecs[i].we));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
      chk($sformatf("v%0d_owner", i), 32'(owner), 32'(vecs[i].own));
      chk($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(vecs[i].drops));
      if (vecs[i].we) begin
        chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
        chk($sformatf("v%0d_data", i), 32'(mem_data), 32'(vecs[i].data));
      end
    end

    // round-robin instance: after owner 1, requester 2 wins, then wrap back to 1
    @(negedge clk);
    drive(3'b000, 3'b000, 4, 0, 3'd2, 1'b0);
    rr_valid = 3'b010; rr_last = 3'b010;
    @(posedge clk); #1;
    chk("rr_first_owner", 32'(rr_owner), 32'd1);
    chk("rr_first_ready", 32'(rr_ready), 32'b010);
    @(negedge clk);
    rr_valid = 3'b110; rr_last = 3'b110;
    @(posedge clk);
    @(posedge clk); #1;
    chk("rr_second_owner", 32'(rr_owner), 32'd2);
    chk("rr_second_ready", 32'(rr_ready), 32'b100);
    @(posedge clk);
    @(posedge clk); #1;
    chk("rr_wrap_owner", 32'(rr_owner), 32'd1);
    @(negedge clk);
    rr_valid = 3'b000; rr_last = 3'b000;

    // asynchronous reset mid-burst, then fresh arbitration
    drive(3'b010, 3'b000, 5, 0, 3'd2, 1'b0);
    @(negedge clk);
    @(negedge clk); #1;
    chk("pre_rst_we", 32'(mem_we), 32'd1);
    chk("pre_rst_addr", 32'(mem_addr), 32'd5);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(mem_we), 32'd0);
    chk("arst_addr", 32'(mem_addr), 32'd0);
    chk("arst_data", 32'(mem_data), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_owner", 32'(owner), 32'd0);
    chk("arst_drop", 32'(drop_cnt), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("post_rst_busy", 32'(busy), 32'd1);
    chk("post_rst_owner", 32'(owner), 32'd1);
    chk("post_rst_ready", 32'(req_ready), 32'b010);

    @(negedge clk);
    drive(3'b000, 3'b000, 0, 0, 3'd0, 1'b0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
